// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
package pong_pkg;

    localparam int VEL_W   = 4;
    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        END   = 3'd4
    } match_state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_e;

    // One velocity step, clamped at the ceiling.
    function automatic logic [VEL_W-1:0] sat_inc(input logic [VEL_W-1:0] v,
                                                 input logic [VEL_W-1:0] vmax);
        return (v >= vmax) ? vmax : v + 1'b1;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Button/collision inputs and match-control outputs between the sequencer
// (slave) and the game datapath / button front end (master).
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic                 frame;
    logic                 btn_fire;
    logic                 btn_pause;
    logic                 hit;
    logic                 miss_l;
    logic                 miss_r;
    match_state_e         state;
    logic                 ball_rst;
    logic                 ball_run;
    logic                 serve_dir;
    logic [VEL_W-1:0]     vel_x;
    logic [VEL_W-1:0]     vel_y;
    logic [SCORE_W-1:0]   score_l;
    logic [SCORE_W-1:0]   score_r;
    logic [1:0]           winner;
    logic [7:0]           countdown;

    modport master (
        output frame, btn_fire, btn_pause, hit, miss_l, miss_r,
        input  state, ball_rst, ball_run, serve_dir, vel_x, vel_y,
               score_l, score_r, winner, countdown
    );

    modport slave (
        input  frame, btn_fire, btn_pause, hit, miss_l, miss_r,
        output state, ball_rst, ball_run, serve_dir, vel_x, vel_y,
               score_l, score_r, winner, countdown
    );

endinterface

// File: rtl/pong_match_ctrl_btn_edge.sv
// btn_edge: 2-flop synchronizer for an asynchronous button level followed
// by a rising-edge detector producing a one-cycle pulse.
module btn_edge (
    input  logic clk_pix,
    input  logic rst_pix_n,
    input  logic i_btn,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronize the raw level and remember the previous synced value.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer (state machine, serve countdown,
// scoring, win detection, ball-speed schedule, pause).
// Optional feature macro: PONG_PAUSE_EN enables the pause button and the
// PAUSE state; without it btn_pause is ignored and PAUSE is unreachable.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN         = 5,
    parameter int SERVE_DELAY = 60,
    parameter int SPEEDUP     = 5,
    parameter int VEL0_X      = 9,
    parameter int VEL0_Y      = 5,
    parameter int VMAX_X      = 10,
    parameter int VMAX_Y      = 10
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    pong_match_ctrl_if.slave  bus
);

    localparam logic [VEL_W-1:0]   V0X = VEL_W'(VEL0_X);
    localparam logic [VEL_W-1:0]   V0Y = VEL_W'(VEL0_Y);
    localparam logic [VEL_W-1:0]   VMX = VEL_W'(VMAX_X);
    localparam logic [VEL_W-1:0]   VMY = VEL_W'(VMAX_Y);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN);
    localparam logic [7:0]         CD_LOAD   = 8'(SERVE_DELAY);
    localparam logic [3:0]         HIT_LAST  = 4'(SPEEDUP - 1);

    logic w_fire_rise;
    logic w_pause_rise;

    btn_edge u_fire (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .i_btn     (bus.btn_fire),
        .o_rise    (w_fire_rise)
    );

`ifdef PONG_PAUSE_EN
    btn_edge u_pause (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .i_btn     (bus.btn_pause),
        .o_rise    (w_pause_rise)
    );
`else
    logic w_unused_pause;
    assign w_unused_pause = bus.btn_pause;
    assign w_pause_rise   = 1'b0;
`endif

    match_state_e       r_state,     w_state_nx;
    logic [7:0]         r_countdown, w_countdown_nx;
    logic [3:0]         r_hits,      w_hits_nx;
    logic [VEL_W-1:0]   r_vel_x,     w_vel_x_nx;
    logic [VEL_W-1:0]   r_vel_y,     w_vel_y_nx;
    logic [SCORE_W-1:0] r_score_l,   w_score_l_nx;
    logic [SCORE_W-1:0] r_score_r,   w_score_r_nx;
    winner_e            r_winner,    w_winner_nx;
    logic               r_serve_dir, w_serve_dir_nx;
    logic               r_ball_rst,  w_ball_rst_nx;
    logic               r_ball_run,  w_ball_run_nx;
    logic               w_miss;
    logic               w_won;

    // Match state and all registered outputs.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_state     <= IDLE;
            r_countdown <= '0;
            r_hits      <= '0;
            r_vel_x     <= V0X;
            r_vel_y     <= V0Y;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_winner    <= WIN_NONE;
            r_serve_dir <= 1'b1;
            r_ball_rst  <= 1'b1;
            r_ball_run  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_countdown <= w_countdown_nx;
            r_hits      <= w_hits_nx;
            r_vel_x     <= w_vel_x_nx;
            r_vel_y     <= w_vel_y_nx;
            r_score_l   <= w_score_l_nx;
            r_score_r   <= w_score_r_nx;
            r_winner    <= w_winner_nx;
            r_serve_dir <= w_serve_dir_nx;
            r_ball_rst  <= w_ball_rst_nx;
            r_ball_run  <= w_ball_run_nx;
        end
    end

    // Next-state and next-output logic; misses outrank hits and pause.
    always_comb begin
        w_state_nx     = r_state;
        w_countdown_nx = r_countdown;
        w_hits_nx      = r_hits;
        w_vel_x_nx     = r_vel_x;
        w_vel_y_nx     = r_vel_y;
        w_score_l_nx   = r_score_l;
        w_score_r_nx   = r_score_r;
        w_winner_nx    = r_winner;
        w_serve_dir_nx = r_serve_dir;
        w_miss         = bus.miss_r | bus.miss_l;
        w_won          = 1'b0;

        case (r_state)
            IDLE: begin
                w_score_l_nx   = '0;
                w_score_r_nx   = '0;
                w_winner_nx    = WIN_NONE;
                w_vel_x_nx     = V0X;
                w_vel_y_nx     = V0Y;
                w_serve_dir_nx = 1'b1;
                w_countdown_nx = '0;
                if (w_fire_rise) begin
                    w_state_nx     = SERVE;
                    w_countdown_nx = CD_LOAD;
                    w_hits_nx      = '0;
                end
            end
            SERVE: begin
                if (bus.frame) begin
                    if (r_countdown == 8'd1) begin
                        w_state_nx     = PLAY;
                        w_countdown_nx = '0;
                    end else begin
                        w_countdown_nx = r_countdown - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (w_miss) begin
                    // miss_r wins a simultaneous pair; the other is dropped
                    if (bus.miss_r) begin
                        w_score_l_nx   = r_score_l + 1'b1;
                        w_serve_dir_nx = 1'b1;
                        w_won          = (w_score_l_nx == WIN_SCORE);
                    end else begin
                        w_score_r_nx   = r_score_r + 1'b1;
                        w_serve_dir_nx = 1'b0;
                        w_won          = (w_score_r_nx == WIN_SCORE);
                    end
                    if (w_won) begin
                        w_state_nx  = END;
                        w_winner_nx = bus.miss_r ? WIN_LEFT : WIN_RIGHT;
                    end else begin
                        w_state_nx     = SERVE;
                        w_countdown_nx = CD_LOAD;
                        w_vel_x_nx     = V0X;
                        w_vel_y_nx     = V0Y;
                        w_hits_nx      = '0;
                    end
                end else begin
                    if (w_pause_rise)
                        w_state_nx = PAUSE;
                    if (bus.hit) begin
                        if (r_hits == HIT_LAST) begin
                            w_hits_nx  = '0;
                            w_vel_x_nx = sat_inc(r_vel_x, VMX);
                            w_vel_y_nx = sat_inc(r_vel_y, VMY);
                        end else begin
                            w_hits_nx = r_hits + 4'd1;
                        end
                    end
                end
            end
            PAUSE: begin
                if (w_pause_rise)
                    w_state_nx = PLAY;
            end
            END: begin
                if (w_fire_rise) begin
                    w_state_nx     = IDLE;
                    w_score_l_nx   = '0;
                    w_score_r_nx   = '0;
                    w_winner_nx    = WIN_NONE;
                    w_vel_x_nx     = V0X;
                    w_vel_y_nx     = V0Y;
                    w_serve_dir_nx = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // Ball controls follow the state being entered so they stay aligned.
        w_ball_rst_nx = (w_state_nx == IDLE) || (w_state_nx == SERVE) ||
                        (w_state_nx == END);
        w_ball_run_nx = (w_state_nx == PLAY);
    end

    assign bus.state     = r_state;
    assign bus.countdown = r_countdown;
    assign bus.vel_x     = r_vel_x;
    assign bus.vel_y     = r_vel_y;
    assign bus.score_l   = r_score_l;
    assign bus.score_r   = r_score_r;
    assign bus.winner    = r_winner;
    assign bus.serve_dir = r_serve_dir;
    assign bus.ball_rst  = r_ball_rst;
    assign bus.ball_run  = r_ball_run;

endmodule
